// File: rtl/toy_bus_arb2ch_node_req_merge_ack_route.sv
// 2-to-1 toy_bus request-merge node: round-robin request arbitration onto out0, with acks
// routed back to the issuing initiator through an in-order grant-history FIFO.
module toy_bus_arb2ch_node_req_merge_ack_route #(
    parameter int unsigned OST_DEPTH = 4,
    parameter int unsigned CNT_W     = $clog2(OST_DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         in0_req_vld,
    output logic         in0_req_rdy,
    input  logic [31:0]  in0_req_addr,
    input  logic [31:0]  in0_req_strb,
    input  logic [255:0] in0_req_data,
    input  logic         in0_req_opcode,
    input  logic [3:0]   in0_req_src_id,
    input  logic [3:0]   in0_req_tgt_id,
    input  logic [9:0]   in0_req_sideband,
    output logic         in0_ack_vld,
    input  logic         in0_ack_rdy,
    output logic         in0_ack_opcode,
    output logic [255:0] in0_ack_data,
    output logic [9:0]   in0_ack_sideband,
    output logic [3:0]   in0_ack_src_id,
    output logic [3:0]   in0_ack_tgt_id,

    input  logic         in1_req_vld,
    output logic         in1_req_rdy,
    input  logic [31:0]  in1_req_addr,
    input  logic [31:0]  in1_req_strb,
    input  logic [255:0] in1_req_data,
    input  logic         in1_req_opcode,
    input  logic [3:0]   in1_req_src_id,
    input  logic [3:0]   in1_req_tgt_id,
    input  logic [9:0]   in1_req_sideband,
    output logic         in1_ack_vld,
    input  logic         in1_ack_rdy,
    output logic         in1_ack_opcode,
    output logic [255:0] in1_ack_data,
    output logic [9:0]   in1_ack_sideband,
    output logic [3:0]   in1_ack_src_id,
    output logic [3:0]   in1_ack_tgt_id,

    output logic         out0_req_vld,
    input  logic         out0_req_rdy,
    output logic [31:0]  out0_req_addr,
    output logic [31:0]  out0_req_strb,
    output logic [255:0] out0_req_data,
    output logic         out0_req_opcode,
    output logic [3:0]   out0_req_src_id,
    output logic [3:0]   out0_req_tgt_id,
    output logic [9:0]   out0_req_sideband,
    input  logic         out0_ack_vld,
    output logic         out0_ack_rdy,
    input  logic         out0_ack_opcode,
    input  logic [255:0] out0_ack_data,
    input  logic [9:0]   out0_ack_sideband,
    input  logic [3:0]   out0_ack_src_id,
    input  logic [3:0]   out0_ack_tgt_id,

    output logic         err_unexp_ack
);

    localparam int unsigned PTR_W = $clog2(OST_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(OST_DEPTH);

    logic                 prio_q;
    logic                 lock_q;
    logic                 lock_idx_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [OST_DEPTH-1:0] fifo_q;
    logic                 err_q;

    logic full;
    logic empty;
    logic lock_hold;
    logic grant;
    logic head;
    logic req_hs;
    logic ack_hs;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // A lock only pins the grant while its owner still requests, so a dropped vld cannot
    // leave the node granting an idle port.
    assign lock_hold = lock_q & (lock_idx_q ? in1_req_vld : in0_req_vld);

    always_comb begin
        grant = 1'b0;
        if (lock_hold) begin
            grant = lock_idx_q;
        end else if (in0_req_vld && in1_req_vld) begin
            grant = prio_q;
        end else begin
            grant = in1_req_vld;
        end
    end

    assign out0_req_vld = (in0_req_vld | in1_req_vld) & ~full;
    assign in0_req_rdy  = ~grant & out0_req_rdy & ~full & in0_req_vld;
    assign in1_req_rdy  = grant & out0_req_rdy & ~full & in1_req_vld;
    assign req_hs       = out0_req_vld & out0_req_rdy;

    assign out0_req_addr     = grant ? in1_req_addr     : in0_req_addr;
    assign out0_req_strb     = grant ? in1_req_strb     : in0_req_strb;
    assign out0_req_data     = grant ? in1_req_data     : in0_req_data;
    assign out0_req_opcode   = grant ? in1_req_opcode   : in0_req_opcode;
    assign out0_req_src_id   = grant ? in1_req_src_id   : in0_req_src_id;
    assign out0_req_tgt_id   = grant ? in1_req_tgt_id   : in0_req_tgt_id;
    assign out0_req_sideband = grant ? in1_req_sideband : in0_req_sideband;

    assign in0_ack_vld  = out0_ack_vld & ~empty & ~head;
    assign in1_ack_vld  = out0_ack_vld & ~empty & head;
    assign out0_ack_rdy = ~empty & (head ? in1_ack_rdy : in0_ack_rdy);
    assign ack_hs       = out0_ack_vld & out0_ack_rdy;

    assign in0_ack_opcode   = out0_ack_opcode;
    assign in0_ack_data     = out0_ack_data;
    assign in0_ack_sideband = out0_ack_sideband;
    assign in0_ack_src_id   = out0_ack_src_id;
    assign in0_ack_tgt_id   = out0_ack_tgt_id;
    assign in1_ack_opcode   = out0_ack_opcode;
    assign in1_ack_data     = out0_ack_data;
    assign in1_ack_sideband = out0_ack_sideband;
    assign in1_ack_src_id   = out0_ack_src_id;
    assign in1_ack_tgt_id   = out0_ack_tgt_id;

    assign err_unexp_ack = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fifo_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (req_hs) begin
                lock_q <= 1'b0;
            end else if (out0_req_vld && !out0_req_rdy) begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant;
            end else begin
                lock_q <= 1'b0;
            end

            if (req_hs) begin
                fifo_q[wr_ptr_q] <= grant;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                prio_q           <= ~grant;
            end
            if (ack_hs) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            if (req_hs && !ack_hs) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!req_hs && ack_hs) begin
                count_q <= count_q - CNT_W'(1);
            end

            if (out0_ack_vld && empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_toy_bus_arb2ch_node_req_merge_ack_route.sv
// Randomized bench for the 2-to-1 request-merge node, checked every cycle against a
// queue-based reference model of arbitration, outstanding history and ack routing.
module tb_toy_bus_arb2ch_node_req_merge_ack_route;

    localparam int unsigned OST_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]   req_vld;
    logic [31:0]  req_addr [2];
    logic [31:0]  req_strb [2];
    logic [255:0] req_data [2];
    logic         req_opcode [2];
    logic [3:0]   req_src [2];
    logic [3:0]   req_tgt [2];
    logic [9:0]   req_sb [2];
    logic [1:0]   ack_rdy;

    logic         in0_req_rdy, in1_req_rdy, in0_ack_vld, in1_ack_vld;
    logic         in0_ack_opcode, in1_ack_opcode;
    logic [255:0] in0_ack_data, in1_ack_data;
    logic [9:0]   in0_ack_sideband, in1_ack_sideband;
    logic [3:0]   in0_ack_src_id, in1_ack_src_id, in0_ack_tgt_id, in1_ack_tgt_id;

    logic         out0_req_vld, out0_req_rdy, out0_req_opcode;
    logic [31:0]  out0_req_addr, out0_req_strb;
    logic [255:0] out0_req_data;
    logic [3:0]   out0_req_src_id, out0_req_tgt_id;
    logic [9:0]   out0_req_sideband;
    logic         out0_ack_vld, out0_ack_rdy, out0_ack_opcode;
    logic [255:0] out0_ack_data;
    logic [9:0]   out0_ack_sideband;
    logic [3:0]   out0_ack_src_id, out0_ack_tgt_id;
    logic         err_unexp_ack;

    toy_bus_arb2ch_node_req_merge_ack_route #(.OST_DEPTH(OST_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_req_vld(req_vld[0]), .in0_req_rdy(in0_req_rdy), .in0_req_addr(req_addr[0]),
        .in0_req_strb(req_strb[0]), .in0_req_data(req_data[0]),
        .in0_req_opcode(req_opcode[0]), .in0_req_src_id(req_src[0]),
        .in0_req_tgt_id(req_tgt[0]), .in0_req_sideband(req_sb[0]),
        .in0_ack_vld(in0_ack_vld), .in0_ack_rdy(ack_rdy[0]), .in0_ack_opcode(in0_ack_opcode),
        .in0_ack_data(in0_ack_data), .in0_ack_sideband(in0_ack_sideband),
        .in0_ack_src_id(in0_ack_src_id), .in0_ack_tgt_id(in0_ack_tgt_id),
        .in1_req_vld(req_vld[1]), .in1_req_rdy(in1_req_rdy), .in1_req_addr(req_addr[1]),
        .in1_req_strb(req_strb[1]), .in1_req_data(req_data[1]),
        .in1_req_opcode(req_opcode[1]), .in1_req_src_id(req_src[1]),
        .in1_req_tgt_id(req_tgt[1]), .in1_req_sideband(req_sb[1]),
        .in1_ack_vld(in1_ack_vld), .in1_ack_rdy(ack_rdy[1]), .in1_ack_opcode(in1_ack_opcode),
        .in1_ack_data(in1_ack_data), .in1_ack_sideband(in1_ack_sideband),
        .in1_ack_src_id(in1_ack_src_id), .in1_ack_tgt_id(in1_ack_tgt_id),
        .out0_req_vld(out0_req_vld), .out0_req_rdy(out0_req_rdy),
        .out0_req_addr(out0_req_addr), .out0_req_strb(out0_req_strb),
        .out0_req_data(out0_req_data), .out0_req_opcode(out0_req_opcode),
        .out0_req_src_id(out0_req_src_id), .out0_req_tgt_id(out0_req_tgt_id),
        .out0_req_sideband(out0_req_sideband),
        .out0_ack_vld(out0_ack_vld), .out0_ack_rdy(out0_ack_rdy),
        .out0_ack_opcode(out0_ack_opcode), .out0_ack_data(out0_ack_data),
        .out0_ack_sideband(out0_ack_sideband), .out0_ack_src_id(out0_ack_src_id),
        .out0_ack_tgt_id(out0_ack_tgt_id),
        .err_unexp_ack(err_unexp_ack)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: grants still awaiting their ack, oldest first.
    int hist[$];
    int prio     = 0;
    bit lock     = 0;
    int lock_idx = 0;
    bit err_m    = 0;

    bit hs_req, hs_ack;
    int g_last;
    int p_vld[2];
    int p_ar[2];
    int p_rdy, p_ack;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic new_req(input int k);
        req_addr[k]   = $urandom;
        req_strb[k]   = $urandom;
        req_data[k]   = rnd256();
        req_opcode[k] = 1'($urandom);
        req_src[k]    = 4'($urandom);
        req_tgt[k]    = 4'($urandom);
        req_sb[k]     = 10'($urandom);
    endtask

    task automatic new_ack();
        out0_ack_opcode   = 1'($urandom);
        out0_ack_data     = rnd256();
        out0_ack_sideband = 10'($urandom);
        out0_ack_src_id   = 4'($urandom);
        out0_ack_tgt_id   = 4'($urandom);
    endtask

    // Entered one time unit after a rising edge; leaves one time unit after the next.
    task automatic check_cycle();
        int  g;
        int  head;
        bit  full, empty, e_ovld, e_ardy;
        bit [1:0] e_rdy, e_avld;
        #3;
        full  = (hist.size() == OST_DEPTH);
        empty = (hist.size() == 0);
        if (lock) g = lock_idx;
        else if (req_vld == 2'b11) g = prio;
        else if (req_vld[1]) g = 1;
        else g = 0;
        e_ovld = (req_vld != 2'b00) && !full;
        for (int k = 0; k < 2; k++) begin
            e_rdy[k] = (g == k) && out0_req_rdy && !full && req_vld[k];
        end
        head = empty ? 0 : hist[0];
        for (int k = 0; k < 2; k++) e_avld[k] = out0_ack_vld && !empty && (head == k);
        e_ardy = !empty && ack_rdy[head];

        chk("out0_req_vld", 512'(out0_req_vld), 512'(e_ovld));
        chk("in_req_rdy", 512'({in1_req_rdy, in0_req_rdy}), 512'(e_rdy));
        chk("in_ack_vld", 512'({in1_ack_vld, in0_ack_vld}), 512'(e_avld));
        chk("out0_ack_rdy", 512'(out0_ack_rdy), 512'(e_ardy));
        chk("err_unexp_ack", 512'(err_unexp_ack), 512'(err_m));
        if (e_ovld) begin
            chk("out0_req_payload",
                512'({out0_req_addr, out0_req_strb, out0_req_data, out0_req_opcode,
                      out0_req_src_id, out0_req_tgt_id, out0_req_sideband}),
                512'({req_addr[g], req_strb[g], req_data[g], req_opcode[g],
                      req_src[g], req_tgt[g], req_sb[g]}));
        end
        chk("in0_ack_payload",
            512'({in0_ack_opcode, in0_ack_data, in0_ack_sideband, in0_ack_src_id,
                  in0_ack_tgt_id}),
            512'({out0_ack_opcode, out0_ack_data, out0_ack_sideband, out0_ack_src_id,
                  out0_ack_tgt_id}));
        chk("in1_ack_payload",
            512'({in1_ack_opcode, in1_ack_data, in1_ack_sideband, in1_ack_src_id,
                  in1_ack_tgt_id}),
            512'({out0_ack_opcode, out0_ack_data, out0_ack_sideband, out0_ack_src_id,
                  out0_ack_tgt_id}));

        hs_req = e_ovld && out0_req_rdy;
        hs_ack = out0_ack_vld && e_ardy;
        g_last = g;
        @(posedge clk);
        if (hs_req) begin
            hist.push_back(g);
            prio = 1 - g;
            lock = 0;
        end else if (e_ovld && !out0_req_rdy) begin
            lock     = 1;
            lock_idx = g;
        end else begin
            lock = 0;
        end
        if (hs_ack) void'(hist.pop_front());
        if (out0_ack_vld && empty) err_m = 1;
        #1;
    endtask

    // Protocol-compliant initiators and target: a pending transfer holds until accepted.
    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            if (!req_vld[k] || (hs_req && g_last == k)) begin
                req_vld[k] = ($urandom % 100) < p_vld[k];
                new_req(k);
            end
            ack_rdy[k] = ($urandom % 100) < p_ar[k];
        end
        out0_req_rdy = ($urandom % 100) < p_rdy;
        if (!out0_ack_vld || hs_ack) begin
            out0_ack_vld = (hist.size() > 0) && (($urandom % 100) < p_ack);
            new_ack();
        end
    endtask

    task automatic run(input int n, input int v0, input int v1, input int rdy, input int ack,
                       input int ar0, input int ar1);
        p_vld[0] = v0; p_vld[1] = v1; p_rdy = rdy; p_ack = ack; p_ar[0] = ar0; p_ar[1] = ar1;
        for (int i = 0; i < n; i++) begin
            drive();
            check_cycle();
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_vld      = 2'b00;
        ack_rdy      = 2'b00;
        out0_req_rdy = 1'b0;
        out0_ack_vld = 1'b0;
        hs_req       = 0;
        hs_ack       = 0;
        g_last       = 0;
        new_req(0);
        new_req(1);
        new_ack();
        #3;
        chk("reset_out0_req_vld", 512'(out0_req_vld), 512'(0));
        chk("reset_in_req_rdy", 512'({in1_req_rdy, in0_req_rdy}), 512'(0));
        chk("reset_in_ack_vld", 512'({in1_ack_vld, in0_ack_vld}), 512'(0));
        chk("reset_out0_ack_rdy", 512'(out0_ack_rdy), 512'(0));
        chk("reset_err", 512'(err_unexp_ack), 512'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-port flow, then strict alternation under continuous requests.
        run(20, 100, 0, 100, 100, 100, 100);
        run(30, 100, 100, 100, 100, 100, 100);
        // Back-pressure with lock, then fill to OST_DEPTH with acks held off, then drain.
        run(150, 60, 60, 30, 50, 80, 80);
        run(12, 100, 100, 100, 0, 100, 100);
        run(20, 100, 100, 100, 100, 100, 100);
        // Mixed routing with ack back-pressure on both initiators.
        run(400, 50, 50, 60, 60, 40, 40);

        // Drain everything, then present an ack nobody is waiting for.
        p_vld[0] = 0; p_vld[1] = 0; p_rdy = 100; p_ack = 100; p_ar[0] = 100; p_ar[1] = 100;
        for (int i = 0; i < 60 && (hist.size() != 0 || req_vld != 2'b00 || out0_ack_vld); i++)
        begin
            drive();
            check_cycle();
        end
        chk("drained", 512'(hist.size() == 0 && req_vld == 2'b00 && !out0_ack_vld), 512'(1));
        out0_ack_vld = 1'b1;
        new_ack();
        check_cycle();
        check_cycle();
        out0_ack_vld = 1'b0;
        check_cycle();
        chk("err_sticky", 512'(err_unexp_ack), 512'(1));

        // Reset in the middle of traffic with requests outstanding.
        run(10, 70, 70, 50, 0, 100, 100);
        #2;
        rst_n = 1'b0;
        hist.delete();
        prio = 0; lock = 0; lock_idx = 0; err_m = 0;
        #1;
        chk("rst_err", 512'(err_unexp_ack), 512'(0));
        chk("rst_out0_ack_rdy", 512'(out0_ack_rdy), 512'(0));
        chk("rst_in_ack_vld", 512'({in1_ack_vld, in0_ack_vld}), 512'(0));
        chk("rst_out0_req_vld", 512'(out0_req_vld), 512'(req_vld != 2'b00));
        req_vld      = 2'b00;
        out0_ack_vld = 1'b0;
        hs_req       = 0;
        hs_ack       = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(40, 100, 100, 80, 80, 70, 70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
